// File: rtl/scsi_initiator.sv
// scsi_initiator: SCSI initiator engine that selects a target and services
// command, data, status and message phases with a req/ack handshake.
module scsi_initiator #(
    parameter logic [2:0] HOST_ID     = 3'd7,
    parameter int         SEL_TIMEOUT = 1024,
    parameter int         ACK_HOLD    = 4,
    parameter int         SETTLE      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  target_id,
    input  logic [79:0] cdb,
    input  logic        bus_reset,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status,
    output logic [7:0]  msg_in,
    output logic        sel_timeout,
    output logic        aborted,
    output logic        phase_err,
    output logic [15:0] xfer_cnt,
    output logic [15:0] buf_addr,
    input  logic [7:0]  buf_rdata,
    output logic [7:0]  buf_wdata,
    output logic        buf_wr,
    output logic        scsi_rst,
    output logic        sel,
    output logic        atn,
    output logic        ack,
    input  logic        bsy,
    input  logic        msg,
    input  logic        cd,
    input  logic        io,
    input  logic        req,
    output logic [7:0]  dout,
    input  logic [7:0]  din
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SELECT   = 3'd1;
    localparam logic [2:0] WAIT_REQ = 3'd2;
    localparam logic [2:0] SETUP    = 3'd3;
    localparam logic [2:0] ACK_HI   = 3'd4;
    localparam logic [2:0] RECOVER  = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;
    localparam logic [31:0] SEL_LAST    = 32'(SEL_TIMEOUT > 0 ? SEL_TIMEOUT - 1 : 0);
    localparam logic [31:0] HOLD_LAST   = 32'(ACK_HOLD > 0 ? ACK_HOLD - 1 : 0);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE > 0 ? SETTLE - 1 : 0);

    logic [2:0]  state;
    logic [2:0]  ph;
    logic [79:0] cdb_q;
    logic [3:0]  idx;
    logic [31:0] tmr;
    logic [3:0]  cdb_len;
    logic [7:0]  cdb_byte;

    // group 0 commands are 6 bytes, everything else is treated as 10
    assign cdb_len  = cdb_q[7:5] == 3'd0 ? 4'd6 : 4'd10;
    assign cdb_byte = idx < cdb_len ? cdb_q[{idx, 3'b000} +: 8] : 8'h00;
    assign atn      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ph          <= 3'd0;
            cdb_q       <= '0;
            idx         <= 4'd0;
            tmr         <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= 8'h00;
            msg_in      <= 8'h00;
            sel_timeout <= 1'b0;
            aborted     <= 1'b0;
            phase_err   <= 1'b0;
            xfer_cnt    <= 16'h0000;
            buf_addr    <= 16'h0000;
            buf_wdata   <= 8'h00;
            buf_wr      <= 1'b0;
            scsi_rst    <= 1'b0;
            sel         <= 1'b0;
            ack         <= 1'b0;
            dout        <= 8'h00;
        end else begin
            done   <= 1'b0;
            buf_wr <= 1'b0;
            if (bus_reset) begin
                scsi_rst <= 1'b1;
                sel      <= 1'b0;
                ack      <= 1'b0;
                dout     <= 8'h00;
                state    <= IDLE;
                if (busy) begin
                    aborted <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end else begin
                scsi_rst <= 1'b0;
                case (state)
                    IDLE: if (start) begin
                        cdb_q       <= cdb;
                        status      <= 8'h00;
                        msg_in      <= 8'h00;
                        sel_timeout <= 1'b0;
                        aborted     <= 1'b0;
                        phase_err   <= 1'b0;
                        xfer_cnt    <= 16'h0000;
                        buf_addr    <= 16'h0000;
                        idx         <= 4'd0;
                        tmr         <= 32'd0;
                        dout        <= (8'd1 << target_id) | (8'd1 << HOST_ID);
                        sel         <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                    SELECT: begin
                        if (bsy) begin
                            sel   <= 1'b0;
                            dout  <= 8'h00;
                            state <= WAIT_REQ;
                        end else if (tmr == SEL_LAST) begin
                            sel_timeout <= 1'b1;
                            sel         <= 1'b0;
                            dout        <= 8'h00;
                            state       <= FINISH;
                        end else
                            tmr <= tmr + 32'd1;
                    end
                    WAIT_REQ: begin
                        if (!bsy)
                            state <= FINISH;
                        else if (req) begin
                            ph    <= {msg, cd, io};
                            dout  <= 8'h00;
                            state <= SETUP;
                            case ({msg, cd, io})
                                3'b010: begin
                                    dout <= cdb_byte;
                                    if (idx != 4'd9) idx <= idx + 4'd1;
                                end
                                3'b000: dout <= buf_rdata;
                                3'b001: begin
                                    buf_wdata <= din;
                                    buf_wr    <= 1'b1;
                                end
                                3'b011: status <= din;
                                3'b111: msg_in <= din;
                                default: phase_err <= 1'b1;
                            endcase
                        end
                    end
                    SETUP: begin
                        ack   <= 1'b1;
                        tmr   <= 32'd0;
                        state <= ACK_HI;
                        if (ph == 3'b001) begin
                            buf_addr <= buf_addr + 16'd1;
                            xfer_cnt <= xfer_cnt + 16'd1;
                        end
                    end
                    ACK_HI: begin
                        if (tmr >= HOLD_LAST && !req) begin
                            ack   <= 1'b0;
                            tmr   <= 32'd0;
                            state <= RECOVER;
                            if (ph == 3'b000) begin
                                buf_addr <= buf_addr + 16'd1;
                                xfer_cnt <= xfer_cnt + 16'd1;
                            end
                        end else if (tmr < HOLD_LAST)
                            tmr <= tmr + 32'd1;
                    end
                    RECOVER: begin
                        if (tmr >= SETTLE_LAST)
                            state <= WAIT_REQ;
                        else
                            tmr <= tmr + 32'd1;
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scsi_initiator.sv
// tb_scsi_initiator: drives scsi_initiator with a behavioural SCSI target and
// host buffer, checking bus traffic and results against spec-level expectations.
module tb_scsi_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  target_id = 3'd0;
    logic [79:0] cdb = '0;
    logic        bus_reset = 1'b0;
    logic        busy, done, sel_timeout, aborted, phase_err, buf_wr;
    logic [7:0]  status, msg_in, buf_wdata, dout;
    logic [15:0] xfer_cnt, buf_addr;
    logic [7:0]  buf_rdata = 8'h00;
    logic        scsi_rst, sel, atn, ack;
    logic        bsy = 1'b0, msg = 1'b0, cd = 1'b0, io = 1'b0, req = 1'b0;
    logic [7:0]  din = 8'h00;

    int total = 0, bad = 0, done_cnt = 0, wr_cnt = 0, hs_to = 0;
    logic [7:0] src [65536];
    logic [7:0] cap [65536];
    logic [7:0] got_cmd [16];

    scsi_initiator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target_id(target_id), .cdb(cdb),
        .bus_reset(bus_reset), .busy(busy), .done(done), .status(status), .msg_in(msg_in),
        .sel_timeout(sel_timeout), .aborted(aborted), .phase_err(phase_err),
        .xfer_cnt(xfer_cnt), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
        .buf_wdata(buf_wdata), .buf_wr(buf_wr), .scsi_rst(scsi_rst), .sel(sel),
        .atn(atn), .ack(ack), .bsy(bsy), .msg(msg), .cd(cd), .io(io), .req(req),
        .dout(dout), .din(din)
    );

    always #5 clk = ~clk;

    // host buffer RAM: data appears one cycle after the address
    always @(posedge clk) buf_rdata <= src[buf_addr];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (buf_wr) begin
            cap[buf_addr] = buf_wdata;
            wr_cnt++;
        end
    end

    function automatic logic [7:0] exp_cmd(input logic [79:0] c, input int k);
        int len;
        len = (c[7:5] == 3'd0) ? 6 : 10;
        if (k >= len) return 8'h00;
        return c[8*k +: 8];
    endfunction

    task automatic pulse_start(input logic [2:0] id, input logic [79:0] c);
        @(negedge clk);
        target_id = id;
        cdb = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target_id = 3'($urandom);
        cdb = {16'($urandom), $urandom, $urandom};
    endtask

    task automatic bring_up(input logic [2:0] id, input logic [79:0] c,
                            output logic [7:0] sd, output logic so);
        pulse_start(id, c);
        sd = dout;
        so = sel;
        bsy = 1'b1;
    endtask

    task automatic xfer(input logic [2:0] p, input logic [7:0] d, output logic [7:0] got);
        int n;
        @(negedge clk);
        {msg, cd, io} = p;
        din = d;
        req = 1'b1;
        n = 0;
        while (!ack && n < 64) begin @(negedge clk); n++; end
        if (!ack) hs_to++;
        got = dout;
        req = 1'b0;
        n = 0;
        while (ack && n < 64) begin @(negedge clk); n++; end
        if (ack) hs_to++;
        din = 8'($urandom);
    endtask

    task automatic send_cmd(input int n);
        for (int k = 0; k < n; k++) xfer(3'b010, 8'($urandom), got_cmd[k]);
    endtask

    task automatic finish_target(input logic [7:0] st, input logic [7:0] mi);
        logic [7:0] g;
        xfer(3'b011, st, g);
        xfer(3'b111, mi, g);
        @(negedge clk);
        bsy = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (busy) hs_to++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] sd;
        logic so;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, done, sel, ack, atn, scsi_rst, buf_wr} !== 7'd0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0", {busy, done, sel, ack, atn, scsi_rst, buf_wr}); end
        total++; if ({dout, status, msg_in, xfer_cnt, buf_addr} !== 56'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {dout, status, msg_in, xfer_cnt, buf_addr}); end
        rst_n = 1'b1;
        bring_up(3'd2, 80'h0, sd, so);
        bsy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, sel, dout} !== 10'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", {busy, sel, dout}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tur();
        logic [7:0] sd;
        logic so;
        int d0;
        d0 = done_cnt;
        bring_up(3'd0, 80'h0, sd, so);
        total++; if (sd !== 8'h81 || so !== 1'b1) begin bad++; $display("FAIL tur_select got=%h/%b exp=81/1", sd, so); end
        send_cmd(6);
        for (int k = 0; k < 6; k++) begin
            total++; if (got_cmd[k] !== 8'h00) begin bad++; $display("FAIL tur_cmd%0d got=%h exp=00", k, got_cmd[k]); end
        end
        finish_target(8'h00, 8'h00);
        wait_idle();
        total++; if ({status, msg_in, xfer_cnt} !== 32'd0) begin bad++; $display("FAIL tur_result got=%h exp=0", {status, msg_in, xfer_cnt}); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL tur_done got=%0d exp=1", done_cnt - d0); end
        total++; if ({sel_timeout, aborted, phase_err} !== 3'b000) begin bad++; $display("FAIL tur_flags got=%b exp=000", {sel_timeout, aborted, phase_err}); end
        total++; if (hs_to !== 0) begin bad++; $display("FAIL tur_handshake got=%0d exp=0", hs_to); end
    endtask

    task automatic test_cmd_random();
        logic [7:0] sd, st, mi;
        logic so;
        logic [2:0] id;
        logic [79:0] c;
        int n, d0;
        for (int r = 0; r < 4; r++) begin
            id = 3'($urandom_range(0, 6));
            c = {16'($urandom), $urandom, $urandom};
            c[7:5] = (r % 2 == 0) ? 3'($urandom_range(1, 2)) : 3'd0;
            n = (r % 2 == 0) ? 10 : 12;
            st = 8'($urandom);
            mi = 8'($urandom);
            d0 = done_cnt;
            bring_up(id, c, sd, so);
            total++; if (sd !== ((8'd1 << id) | 8'h80)) begin bad++; $display("FAIL rnd_select got=%h exp=%h", sd, (8'd1 << id) | 8'h80); end
            send_cmd(n);
            for (int k = 0; k < n; k++) begin
                total++; if (got_cmd[k] !== exp_cmd(c, k)) begin bad++; $display("FAIL rnd_cmd%0d got=%h exp=%h", k, got_cmd[k], exp_cmd(c, k)); end
            end
            finish_target(st, mi);
            wait_idle();
            total++; if (status !== st || msg_in !== mi) begin bad++; $display("FAIL rnd_status got=%h/%h exp=%h/%h", status, msg_in, st, mi); end
            total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rnd_done got=%0d exp=1", done_cnt - d0); end
        end
    endtask

    task automatic test_read();
        logic [7:0] sd, g;
        logic so;
        logic [7:0] rd [512];
        int w0, miss;
        for (int i = 0; i < 512; i++) rd[i] = 8'($urandom);
        w0 = wr_cnt;
        bring_up(3'd2, 80'h00_00_00_00_00_01_05_00_00_08, sd, so);
        send_cmd(6);
        total++; if ({got_cmd[0], got_cmd[3], got_cmd[4]} !== 24'h08_05_01) begin bad++; $display("FAIL read_cmd got=%h exp=080501", {got_cmd[0], got_cmd[3], got_cmd[4]}); end
        for (int i = 0; i < 512; i++) xfer(3'b001, rd[i], g);
        finish_target(8'h00, 8'h00);
        wait_idle();
        miss = 0;
        for (int i = 0; i < 512; i++) if (cap[i] !== rd[i]) miss++;
        total++; if (wr_cnt - w0 !== 512) begin bad++; $display("FAIL read_wr_pulses got=%0d exp=512", wr_cnt - w0); end
        total++; if (miss !== 0) begin bad++; $display("FAIL read_data got=%0d_bad_bytes exp=0", miss); end
        total++; if (xfer_cnt !== 16'd512 || buf_addr !== 16'd512) begin bad++; $display("FAIL read_count got=%0d/%0d exp=512", xfer_cnt, buf_addr); end
        total++; if (status !== 8'h00 || phase_err !== 1'b0) begin bad++; $display("FAIL read_status got=%h/%b exp=00/0", status, phase_err); end
    endtask

    task automatic test_write();
        logic [7:0] sd, g;
        logic so;
        int miss;
        for (int i = 0; i < 512; i++) src[i] = 8'(i);
        bring_up(3'd5, 80'h00_00_00_00_00_01_00_00_00_0A, sd, so);
        send_cmd(6);
        miss = 0;
        for (int i = 0; i < 512; i++) begin
            xfer(3'b000, 8'($urandom), g);
            if (g !== 8'(i)) miss++;
        end
        finish_target(8'h00, 8'h00);
        wait_idle();
        total++; if (miss !== 0) begin bad++; $display("FAIL write_data got=%0d_bad_bytes exp=0", miss); end
        total++; if (xfer_cnt !== 16'd512) begin bad++; $display("FAIL write_count got=%0d exp=512", xfer_cnt); end
        total++; if (status !== 8'h00 || hs_to !== 0) begin bad++; $display("FAIL write_status got=%h/%0d exp=00/0", status, hs_to); end
    endtask

    task automatic test_phase_err();
        logic [7:0] sd, g1, g2;
        logic so;
        logic [79:0] c;
        c = {16'($urandom), $urandom, $urandom} | 80'hFF_FF_FF_FF_FF_FF;
        c[7:5] = 3'd0;
        bring_up(3'd1, c, sd, so);
        send_cmd(6);
        xfer(3'b100, 8'($urandom), g1);
        xfer(3'b101, 8'($urandom), g2);
        total++; if (g1 !== 8'h00 || g2 !== 8'h00) begin bad++; $display("FAIL perr_dout got=%h/%h exp=00", g1, g2); end
        finish_target(8'h02, 8'h00);
        wait_idle();
        total++; if (phase_err !== 1'b1 || status !== 8'h02) begin bad++; $display("FAIL perr_flag got=%b/%h exp=1/02", phase_err, status); end
    endtask

    task automatic test_timeout();
        int n, d0;
        d0 = done_cnt;
        pulse_start(3'd3, {16'($urandom), $urandom, $urandom});
        n = 0;
        while (sel && n < 3000) begin n++; @(negedge clk); end
        wait_idle();
        total++; if (n !== 1024) begin bad++; $display("FAIL timeout_sel_cycles got=%0d exp=1024", n); end
        total++; if (sel_timeout !== 1'b1 || sel !== 1'b0) begin bad++; $display("FAIL timeout_flag got=%b/%b exp=1/0", sel_timeout, sel); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL timeout_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_bus_reset();
        logic [7:0] sd, g, st;
        logic so;
        int d0;
        bring_up(3'd4, 80'h00_00_00_00_00_01_05_00_00_08, sd, so);
        send_cmd(6);
        for (int i = 0; i < 100; i++) xfer(3'b001, 8'($urandom), g);
        d0 = done_cnt;
        @(negedge clk);
        bus_reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({scsi_rst, ack, sel, busy} !== 4'b1000 || dout !== 8'h00) begin bad++; $display("FAIL busrst_bus got=%b/%h exp=1000/00", {scsi_rst, ack, sel, busy}, dout); end
        total++; if (aborted !== 1'b1 || xfer_cnt !== 16'd100) begin bad++; $display("FAIL busrst_abort got=%b/%0d exp=1/100", aborted, xfer_cnt); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busrst_done got=%0d exp=1", done_cnt - d0); end
        bus_reset = 1'b0;
        bsy = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (scsi_rst !== 1'b0 || aborted !== 1'b1) begin bad++; $display("FAIL busrst_release got=%b/%b exp=0/1", scsi_rst, aborted); end
        st = 8'($urandom);
        d0 = done_cnt;
        bring_up(3'd6, 80'h0, sd, so);
        send_cmd(6);
        finish_target(st, 8'h00);
        wait_idle();
        total++; if (aborted !== 1'b0 || status !== st || done_cnt - d0 !== 1) begin bad++; $display("FAIL busrst_restart got=%b/%h/%0d exp=0/%h/1", aborted, status, done_cnt - d0, st); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sd, sd2;
        logic so, so2;
        logic [79:0] c;
        logic [2:0] id;
        int d0;
        c = {16'($urandom), $urandom, $urandom};
        c[7:5] = 3'd0;
        id = 3'($urandom_range(0, 6));
        d0 = done_cnt;
        bring_up(id, c, sd, so);
        xfer(3'b010, 8'h00, got_cmd[0]);
        xfer(3'b010, 8'h00, got_cmd[1]);
        pulse_start(3'(id + 3'd1), ~c);
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL busy_start_sel got=%b exp=0", sel); end
        for (int k = 2; k < 6; k++) xfer(3'b010, 8'h00, got_cmd[k]);
        for (int k = 0; k < 6; k++) begin
            total++; if (got_cmd[k] !== exp_cmd(c, k)) begin bad++; $display("FAIL busy_cmd%0d got=%h exp=%h", k, got_cmd[k], exp_cmd(c, k)); end
        end
        finish_target(8'h00, 8'h00);
        wait_idle();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_done got=%0d exp=1", done_cnt - d0); end
        bring_up(3'd3, 80'h0, sd2, so2);
        total++; if (sd2 !== 8'h88 || so2 !== 1'b1) begin bad++; $display("FAIL b2b_select got=%h/%b exp=88/1", sd2, so2); end
        send_cmd(6);
        finish_target(8'h00, 8'h00);
        wait_idle();
        total++; if (done_cnt - d0 !== 2 || hs_to !== 0) begin bad++; $display("FAIL b2b_done got=%0d/%0d exp=2/0", done_cnt - d0, hs_to); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tur();
        test_cmd_random();
        test_read();
        test_write();
        test_phase_err();
        test_timeout();
        test_bus_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
